// File: rtl/dut_reg_pkg.sv
// Shared constants and data-word type for the dut_reg loadable/incrementing register.
package dut_reg_pkg;

   localparam int DUT_REG_WIDTH   = 8;
   localparam int DUT_REG_RST_VAL = 0;

   typedef logic [DUT_REG_WIDTH-1:0] dut_reg_word_t;

endpackage : dut_reg_pkg

// File: rtl/dut_reg_incr.sv
// Combinational +1 for dut_reg: wraps modulo 2^WIDTH, or saturates at all-ones
// when DUT_REG_SAT_EN is defined.
module dut_reg_incr
   import dut_reg_pkg::*;
#(
   parameter int WIDTH = DUT_REG_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

`ifdef DUT_REG_SAT_EN
   // NOTE: y gets a default before the conditional so no latch is inferred.
   always_comb begin
      y = a;
      if (a != '1) y = a + WIDTH'(1);
   end
`else
   assign y = a + WIDTH'(1);
`endif

endmodule : dut_reg_incr

// File: rtl/dut_reg.sv
// Loadable, incrementing WIDTH-bit register with synchronous active-high reset on rst_n.
// Build option DUT_REG_SAT_EN: saturating increment plus a registered `sat` flag.
module dut_reg
   import dut_reg_pkg::*;
#(
   parameter int               WIDTH   = DUT_REG_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DUT_REG_RST_VAL)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic             inc,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
`ifdef DUT_REG_SAT_EN
   ,
   output logic             sat
`endif
);

   logic [WIDTH-1:0] state_d, state_q;
   logic [WIDTH-1:0] state_inc;

   dut_reg_incr #(.WIDTH(WIDTH)) u_incr (
      .a (state_q),
      .y (state_inc)
   );

   // Load beats increment; reset is applied in the flop process and beats both.
   always_comb begin
      state_d = state_q;
      if (ld)       state_d = in;
      else if (inc) state_d = state_inc;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst_n) state_q <= RST_VAL;
      else       state_q <= state_d;
   end

   assign out = state_q;

`ifdef DUT_REG_SAT_EN
   logic sat_d, sat_q;

   // Flag is registered alongside the state so it tracks out with no extra delay.
   always_comb begin
      sat_d = (state_d == '1);
   end

   always_ff @(posedge clk) begin
      if (rst_n) sat_q <= (RST_VAL == '1);
      else       sat_q <= sat_d;
   end

   assign sat = sat_q;
`endif

endmodule : dut_reg

// File: tb/tb_dut_reg.sv
// Self-checking bench for dut_reg: directed vector table plus a random regression
// against a reference model, with expected values queued in a scoreboard.
module tb_dut_reg;
   import dut_reg_pkg::*;

   typedef struct {
      logic          rst;
      logic          ld;
      logic          inc;
      dut_reg_word_t din;
      dut_reg_word_t exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ld;
   logic          inc;
   dut_reg_word_t din;
   dut_reg_word_t dout;
`ifdef DUT_REG_SAT_EN
   logic          sat;
`endif

   dut_reg dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (ld),
      .inc   (inc),
      .in    (din),
      .out   (dout)
`ifdef DUT_REG_SAT_EN
      ,
      .sat   (sat)
`endif
   );

   always #5 clk = ~clk;

   int            n_vec = 0;
   int            n_err = 0;
   dut_reg_word_t sb_q[$];
   vec_t          vecs[$];
   dut_reg_word_t model;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (got %0t, required finish earlier)", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic dut_reg_word_t model_next(input dut_reg_word_t cur, input logic r,
                                                input logic l, input logic i,
                                                input dut_reg_word_t d);
      if (r) return dut_reg_word_t'(DUT_REG_RST_VAL);
      if (l) return d;
      if (i) begin
`ifdef DUT_REG_SAT_EN
         if (cur == '1) return cur;
`endif
         return cur + 1'b1;
      end
      return cur;
   endfunction

   function automatic void add(input logic r, input logic l, input logic i,
                               input logic [7:0] d, input logic [7:0] e);
      vec_t v;
      v.rst = r; v.ld = l; v.inc = i; v.din = d; v.exp = e;
      vecs.push_back(v);
   endfunction

   // Drive one edge's worth of inputs at negedge, queue the expectation, compare #1 after posedge.
   task automatic apply(input string name, input logic r, input logic l, input logic i,
                        input dut_reg_word_t d, input dut_reg_word_t e);
      dut_reg_word_t want;
      @(negedge clk);
      rst_n = r; ld = l; inc = i; din = d;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      want = sb_q.pop_front();
      check(name, 32'(dout), 32'(want));
`ifdef DUT_REG_SAT_EN
      check({name, "_sat"}, 32'(sat), 32'(want == '1));
`endif
      // Glitch inputs between edges; they must have no effect on the next sample.
      ld = 1'($urandom); inc = 1'($urandom); din = dut_reg_word_t'($urandom);
   endtask

   initial begin
      rst_n = 1'b1; ld = 1'b0; inc = 1'b0; din = '0;

      // Reset overrides load and increment.
      add(1, 1, 0, 8'hA5, 8'h00);
      add(1, 0, 1, 8'h00, 8'h00);
      add(1, 0, 1, 8'h00, 8'h00);
      add(1, 0, 1, 8'h00, 8'h00);
      // Load, then hold for five edges.
      add(0, 1, 0, 8'h3C, 8'h3C);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 8'h77, 8'h3C);
      // Increment across the top of the range.
      add(0, 1, 0, 8'hFD, 8'hFD);
      add(0, 0, 1, 8'h00, 8'hFE);
      add(0, 0, 1, 8'h00, 8'hFF);
`ifdef DUT_REG_SAT_EN
      add(0, 0, 1, 8'h00, 8'hFF);
      add(0, 0, 1, 8'h00, 8'hFF);
`else
      add(0, 0, 1, 8'h00, 8'h00);
      add(0, 0, 1, 8'h00, 8'h01);
`endif
      // Priority: load over increment, reset over both.
      add(0, 1, 0, 8'h10, 8'h10);
      add(0, 1, 1, 8'h80, 8'h80);
      add(0, 1, 0, 8'h10, 8'h10);
      add(1, 1, 1, 8'h80, 8'h00);
      // Same-value load is a legal no-change.
      add(0, 1, 0, 8'h00, 8'h00);
      // Mid-run reset, then resume.
      add(0, 1, 0, 8'h05, 8'h05);
      add(0, 0, 1, 8'h00, 8'h06);
      add(0, 0, 1, 8'h00, 8'h07);
      add(0, 0, 1, 8'h00, 8'h08);
      add(1, 0, 1, 8'h00, 8'h00);
      add(0, 0, 1, 8'h00, 8'h01);

      foreach (vecs[k])
         apply($sformatf("vec%0d", k), vecs[k].rst, vecs[k].ld, vecs[k].inc,
               vecs[k].din, vecs[k].exp);

      // Hand sequence: hold at all-ones, then increment from there.
      apply("ff_load", 0, 1, 0, 8'hFF, 8'hFF);
      apply("ff_hold", 0, 0, 0, 8'h00, 8'hFF);
`ifdef DUT_REG_SAT_EN
      apply("ff_inc", 0, 0, 1, 8'h00, 8'hFF);
`else
      apply("ff_inc", 0, 0, 1, 8'h00, 8'h00);
`endif

      // Random regression against the reference model.
      model = dout;
      for (int c = 0; c < 1000; c++) begin
         logic          r, l, i;
         dut_reg_word_t d;
         r = ($urandom_range(31) == 0);
         l = 1'($urandom);
         i = 1'($urandom);
         d = dut_reg_word_t'($urandom);
         model = model_next(model, r, l, i, d);
         apply($sformatf("rand%0d", c), r, l, i, d, model);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_dut_reg
